// File: rtl/mac_tx_framer.sv
// Ethernet TX framer: preamble, SFD, header, payload, pad, FCS, IPG on a
// DATA_W (8 or 4) PHY bus. Optional 802.1Q tag via `VLAN_TAG_EN.
// Ports: clk, rst (async, active low); s_data/s_valid/s_last/s_ready byte
// source; dest_mac, ethertype (vlan_tci) per frame; txd, txen to PHY;
// busy, frame_done, tx_err status.

module crc32 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [31:0]      crc
);

  logic [31:0] nxt;

  // Reflected CRC-32, LSB of the data first.
  always_comb begin
    nxt = crc;
    for (int i = 0; i < WIDTH; i++) begin
      nxt = (nxt >> 1) ^
            ((nxt[0] ^ data[i]) ? 32'hEDB88320 : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc <= '1;
    else if (init) crc <= '1;
    else if (en) crc <= nxt;
  end

endmodule

module mac_tx_framer #(
  parameter logic [47:0] MAC_ADDR     = 48'h0,
  parameter int          DATA_W       = 8,
  parameter int          PREAMBLE_LEN = 7,
  parameter int          IPG_BYTES    = 12,
  parameter int          MIN_FRAME    = 60,
  parameter int          MAX_PAYLOAD  = 1500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [47:0]       dest_mac,
  input  logic [15:0]       ethertype,
`ifdef VLAN_TAG_EN
  input  logic [15:0]       vlan_tci,
`endif
  output logic [DATA_W-1:0] txd,
  output logic              txen,
  output logic              busy,
  output logic              frame_done,
  output logic              tx_err
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DEST, SRC, VLAN,
    TYPE, PAYLOAD, PAD, FCS, IPG
  } state_t;

`ifdef VLAN_TAG_EN
  localparam int HW = 144;
  logic [HW-1:0] hdr_init;
  assign hdr_init = {dest_mac, MAC_ADDR,
                     16'h8100, vlan_tci, ethertype};
`else
  localparam int HW = 112;
  logic [HW-1:0] hdr_init;
  assign hdr_init = {dest_mac, MAC_ADDR, ethertype};
`endif

  state_t st, ns, es;
  logic [11:0] cnt, ec, flen;
  logic ph, se, err, lst;
  logic start, under, over, acc, a_last, done;
  logic tx_on, hdr_en, crc_en;
  logic [7:0] hold, b, sh, fcs_b;
  logic [DATA_W-1:0] nib;
  logic [HW-1:0] hdr;
  logic [31:0] crc;

  assign s_ready = (st == PAYLOAD) && !ph;

  crc32 #(.WIDTH(DATA_W)) u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (start),
    .en   (crc_en),
    .data (nib),
    .crc  (crc)
  );

  always_comb begin
    case (ec[1:0])
      2'd0: fcs_b = crc[7:0];
      2'd1: fcs_b = crc[15:8];
      2'd2: fcs_b = crc[23:16];
      default: fcs_b = crc[31:24];
    endcase
  end

  // The state machine produces the symbol that txd shows next cycle.
  // Frame start and underrun redirect the current cycle (es/ec) so the
  // wire never idles between the redirect and the next symbol.
  always_comb begin
    es     = st;
    ec     = cnt;
    start  = 1'b0;
    under  = 1'b0;
    over   = 1'b0;
    done   = 1'b0;
    b      = 8'h00;
    if (st == IDLE && s_valid) begin
      es    = PREAMBLE;
      ec    = '0;
      start = 1'b1;
    end
    if (st == PAYLOAD && !ph && !s_valid) begin
      es    = FCS;
      ec    = '0;
      under = 1'b1;
    end
    acc    = (st == PAYLOAD) && !ph && s_valid;
    a_last = ph ? lst : s_last;
    se     = (DATA_W == 8) || ph || (es == IDLE);
    ns     = es;
    case (es)
      PREAMBLE: begin
        b = 8'h55;
        if (ec == 12'(PREAMBLE_LEN - 1)) ns = SFD;
      end
      SFD: begin
        b  = 8'hD5;
        ns = DEST;
      end
      DEST: begin
        b = hdr[HW-1 -: 8];
        if (ec == 12'd5) ns = SRC;
      end
      SRC: begin
        b = hdr[HW-1 -: 8];
`ifdef VLAN_TAG_EN
        if (ec == 12'd5) ns = VLAN;
`else
        if (ec == 12'd5) ns = TYPE;
`endif
      end
      VLAN: begin
        b = hdr[HW-1 -: 8];
        if (ec == 12'd3) ns = TYPE;
      end
      TYPE: begin
        b = hdr[HW-1 -: 8];
        if (ec == 12'd1) ns = PAYLOAD;
      end
      PAYLOAD: begin
        b = ph ? hold : s_data;
        over = acc && !s_last &&
               (ec == 12'(MAX_PAYLOAD - 1));
        if (a_last)
          ns = (flen + 12'd1 < 12'(MIN_FRAME)) ? PAD : FCS;
        else if (ec == 12'(MAX_PAYLOAD - 1))
          ns = FCS;
      end
      PAD: begin
        b = 8'h00;
        if (flen + 12'd1 == 12'(MIN_FRAME)) ns = FCS;
      end
      FCS: begin
        // Errored frames send the raw CRC so the FCS can never match.
        b = (err || under) ? fcs_b : ~fcs_b;
        if (ec == 12'd3) begin
          ns   = IPG;
          done = se;
        end
      end
      IPG: begin
        if (ec == 12'(IPG_BYTES - 1)) ns = IDLE;
      end
      default: ns = IDLE;
    endcase
    if (!se) ns = es;
    sh     = ph ? {4'h0, b[7:4]} : b;
    nib    = sh[DATA_W-1:0];
    tx_on  = (es != IDLE) && (es != IPG);
    hdr_en = es inside {DEST, SRC, VLAN, TYPE};
    crc_en = es inside {DEST, SRC, VLAN, TYPE, PAYLOAD, PAD};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      cnt        <= '0;
      ph         <= 1'b0;
      flen       <= '0;
      err        <= 1'b0;
      hdr        <= '0;
      hold       <= '0;
      lst        <= 1'b0;
      txd        <= '0;
      txen       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      st <= ns;
      ph <= !se;
      if (se)
        cnt <= (ns != es || ns == IDLE) ? '0 : ec + 12'd1;
      else
        cnt <= ec;
      if (start) begin
        hdr  <= hdr_init;
        flen <= '0;
        err  <= 1'b0;
      end else begin
        if (se && hdr_en) hdr <= hdr << 8;
        if (se && crc_en) flen <= flen + 12'd1;
        if (under || over) err <= 1'b1;
      end
      if (acc) begin
        hold <= s_data;
        lst  <= s_last;
      end
      txd        <= tx_on ? nib : '0;
      txen       <= tx_on;
      busy       <= es != IDLE;
      frame_done <= done;
      tx_err     <= under || over;
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed bench for mac_tx_framer: byte (8) and nibble (4) builds
// side by side, frame capture with CRC residue checks.

module tb_mac_tx_framer;

  localparam logic [47:0] SRCM = 48'h02_11_22_33_44_55;
  localparam logic [31:0] GOOD = 32'hDEBB20E3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] dmac = 48'h00_1A_2B_3C_4D_5E;
  logic [15:0] ety  = 16'h0800;
  logic [15:0] tci  = 16'h0064;

  logic [7:0] d8 = '0, d4 = '0;
  logic v8 = 0, l8 = 0, v4 = 0, l4 = 0;
  logic r8, r4, txen8, txen4, busy8, busy4;
  logic done8, done4, err8, err4;
  logic [7:0] txd8;
  logic [3:0] txd4;

  mac_tx_framer #(.MAC_ADDR(SRCM), .DATA_W(8)) u8 (
    .clk(clk), .rst(rst), .s_data(d8), .s_valid(v8),
    .s_last(l8), .s_ready(r8), .dest_mac(dmac),
    .ethertype(ety),
`ifdef VLAN_TAG_EN
    .vlan_tci(tci),
`endif
    .txd(txd8), .txen(txen8), .busy(busy8),
    .frame_done(done8), .tx_err(err8)
  );

  mac_tx_framer #(.MAC_ADDR(SRCM), .DATA_W(4)) u4 (
    .clk(clk), .rst(rst), .s_data(d4), .s_valid(v4),
    .s_last(l4), .s_ready(r4), .dest_mac(dmac),
    .ethertype(ety),
`ifdef VLAN_TAG_EN
    .vlan_tci(tci),
`endif
    .txd(txd4), .txen(txen4), .busy(busy4),
    .frame_done(done4), .tx_err(err4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resid(input logic [7:0] q[$]);
    logic [31:0] c;
    c = '1;
    for (int i = 8; i < q.size(); i++)
      for (int k = 0; k < 8; k++)
        c = (c >> 1) ^ ((c[0] ^ q[i][k]) ? 32'hEDB88320 : 32'h0);
    return c;
  endfunction

  // Mismatching bytes between a captured frame and the expected
  // preamble..pad image for an n-byte payload 1,2,3...
  function automatic int diff(input logic [7:0] q[$], input int n);
    logic [7:0] e[$];
    logic [47:0] dm, sm;
    int bad;
    e = {};
    dm = dmac;
    sm = SRCM;
    repeat (7) e.push_back(8'h55);
    e.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) e.push_back(dm[8*i +: 8]);
    for (int i = 5; i >= 0; i--) e.push_back(sm[8*i +: 8]);
`ifdef VLAN_TAG_EN
    e.push_back(8'h81);
    e.push_back(8'h00);
    e.push_back(tci[15:8]);
    e.push_back(tci[7:0]);
`endif
    e.push_back(ety[15:8]);
    e.push_back(ety[7:0]);
    for (int i = 0; i < n; i++) e.push_back(8'(i + 1));
    while (e.size() - 8 < 60) e.push_back(8'h00);
    bad = 0;
    if (q.size() != e.size() + 4) bad = 1000;
    else
      for (int i = 0; i < e.size(); i++)
        if (q[i] !== e[i]) bad++;
    return bad;
  endfunction

  logic [7:0] cur8[$], last8[$], cur4[$], last4[$];
  logic [31:0] res8q[$], res4q[$];
  int len8q[$], len4q[$];
  int ndone8 = 0, nerr8 = 0, nipg8 = 0, gap8 = 0, zr8 = 0;
  int ndone4 = 0, nerr4 = 0, nipg4 = 0;
  logic pen8 = 0, pen4 = 0, half = 0;
  logic [3:0] lo = '0;

  always @(negedge clk) begin
    if (done8) ndone8++;
    if (err8) nerr8++;
    if (busy8 && !txen8) nipg8++;
    if (txen8) begin
      if (!pen8) gap8 = zr8;
      cur8.push_back(txd8);
    end else begin
      if (pen8) begin
        last8 = cur8;
        cur8 = {};
        len8q.push_back(last8.size());
        res8q.push_back(resid(last8));
        zr8 = 0;
      end
      zr8++;
    end
    pen8 = txen8;
  end

  always @(negedge clk) begin
    if (done4) ndone4++;
    if (err4) nerr4++;
    if (busy4 && !txen4) nipg4++;
    if (txen4) begin
      if (!half) lo = txd4;
      else cur4.push_back({txd4, lo});
      half = !half;
    end else begin
      half = 0;
      if (pen4) begin
        last4 = cur4;
        cur4 = {};
        len4q.push_back(last4.size());
        res4q.push_back(resid(last4));
      end
    end
    pen4 = txen4;
  end

  task automatic drive(input bit w4, input logic v,
                       input logic [7:0] d, input logic l);
    if (w4) begin
      v4 = v; d4 = d; l4 = l;
    end else begin
      v8 = v; d8 = d; l8 = l;
    end
  endtask

  function automatic logic rdy(input bit w4);
    return w4 ? r4 : r8;
  endfunction

  // Offers n bytes; stops early at byte 'cut' (underrun) or when the
  // framer stops accepting. Leaves s_valid as last driven.
  task automatic send(input bit w4, input int n, input int cut,
                      output int acc);
    int k, lim;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (cut > 0 && i == cut) break;
      lim = (i == 0) ? 80 : 12;
      if (w4) lim = lim * 2;
      drive(w4, 1'b1, 8'(i + 1), i == n - 1);
      k = 0;
      while (!rdy(w4) && k < lim) begin
        @(negedge clk);
        k++;
      end
      if (!rdy(w4)) break;
      @(negedge clk);
      acc++;
    end
  endtask

  task automatic wait_idle(input bit w4, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((w4 ? busy4 : busy8) && k < 400);
    chk(tag, w4 ? busy4 : busy8, 0);
  endtask

  int a, a2, sd, se_, si, rc;
  logic saw;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txen", txen8, 0);
    chk("rst_txd", txd8, 0);
    chk("rst_ready", r8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_err", err8, 0);
    rst = 1'b1;
    @(negedge clk);

    sd = ndone8; se_ = nerr8; si = nipg8;
    send(0, 10, 0, a);
    v8 = 0;
    wait_idle(0, "t1_idle");
    chk("t1_acc", a, 10);
    chk("t1_len", len8q[$], 72);
    chk("t1_bytes", diff(last8, 10), 0);
    chk("t1_res", res8q[$], GOOD);
    chk("t1_done", ndone8 - sd, 1);
    chk("t1_ipg", nipg8 - si, 12);
    chk("t1_err", nerr8 - se_, 0);

    sd = ndone4; si = nipg4;
    send(1, 10, 0, a);
    v4 = 0;
    wait_idle(1, "t2_idle");
    chk("t2_acc", a, 10);
    chk("t2_len", len4q[$], 72);
    chk("t2_bytes", diff(last4, 10), 0);
    chk("t2_res", res4q[$], GOOD);
    chk("t2_done", ndone4 - sd, 1);
    chk("t2_ipg", nipg4 - si, 24);

    send(0, 100, 0, a);
    send(0, 100, 0, a2);
    v8 = 0;
    wait_idle(0, "t3_idle");
    chk("t3_acc", a + a2, 200);
    chk("t3_len1", len8q[$-1], 126);
    chk("t3_len2", len8q[$], 126);
    chk("t3_res1", res8q[$-1], GOOD);
    chk("t3_res2", res8q[$], GOOD);
    chk("t3_bytes2", diff(last8, 100), 0);
    chk("t3_gap", gap8, 12);

    se_ = nerr8;
    send(0, 200, 20, a);
    v8 = 0;
    wait_idle(0, "t4_idle");
    chk("t4_acc", a, 20);
    chk("t4_err", nerr8 - se_, 1);
    chk("t4_len", len8q[$], 46);
    chk("t4_res_bad", res8q[$] == GOOD, 0);

    se_ = nerr8;
    send(0, 1501, 0, a);
    v8 = 0;
    rc = 0;
    while (busy8 && rc < 400) begin
      if (r8) rc = rc + 1000;
      @(negedge clk);
      rc++;
    end
    chk("t5_acc", a, 1500);
    chk("t5_ready_tail", rc >= 1000, 0);
    chk("t5_err", nerr8 - se_, 1);
    chk("t5_len", len8q[$], 1526);
    chk("t5_res_bad", res8q[$] == GOOD, 0);

`ifdef VLAN_TAG_EN
    send(0, 10, 0, a);
    v8 = 0;
    wait_idle(0, "t6_idle");
    chk("t6_tag", {last8[20], last8[21], last8[22], last8[23]},
        32'h8100_0064);
    chk("t6_bytes", diff(last8, 10), 0);
    chk("t6_res", res8q[$], GOOD);
`endif

    drive(0, 1'b1, 8'h77, 1'b0);
    saw = 0;
    for (int k = 0; k < 80 && !saw; k++) begin
      @(negedge clk);
      saw = r8;
    end
    repeat (3) @(negedge clk);
    chk("mid_txen_pre", txen8, 1);
    rst = 1'b0;
    #1;
    chk("mid_ready_seen", saw, 1);
    chk("mid_txen", txen8, 0);
    chk("mid_txd", txd8, 0);
    chk("mid_busy", busy8, 0);
    chk("mid_ready", r8, 0);
    chk("mid_err", err8, 0);
    chk("mid_done", done8, 0);
    v8 = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
